// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one broadcast bus between drvrs fifo-fronted terminals.
// Define BUS_ARBITER_STATS_EN to add saturating delivered/dropped packet counters.
module bus_arbiter #(
  parameter int         drvrs = 4,
  parameter int         width = 16,
  parameter logic [7:0] bcast = 8'hFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [drvrs-1:0]       pndng_i,
  input  logic [drvrs*width-1:0] dato_i,
  output logic [drvrs-1:0]       pop_o,
  output logic [drvrs-1:0]       push_o,
  output logic [width-1:0]       dato_o,
  output logic [drvrs-1:0]       grant_o,
  output logic                   busy_o,
  output logic                   err_o
`ifdef BUS_ARBITER_STATS_EN
  ,
  output logic [15:0]            pkt_cnt_o,
  output logic [15:0]            drop_cnt_o
`endif
);

  // state   | meaning
  // IDLE    | sample pndng_i, pick next requester from ptr onwards
  // GRANT   | pop the granted fifo, latch its fall-through head word
  // DELIVER | push the latched packet to its destination(s) or drop it

  localparam int         IW     = $clog2(drvrs);
  localparam logic [7:0] DRVRS8 = 8'(drvrs);

  typedef enum logic [1:0] {IDLE, GRANT, DELIVER} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     ptr, ptr_nxt;
  logic [IW-1:0]     sel, sel_nxt;

  logic [drvrs-1:0]  pop_nxt, push_nxt, grant_nxt;
  logic [width-1:0]  dato_nxt;
  logic              busy_nxt, err_nxt;

  logic [width-1:0]  heads [drvrs];
  logic [width-1:0]  head;
  logic [7:0]        dest;
  logic [drvrs-1:0]  dest_push;

  logic              rr_hit;
  logic [IW-1:0]     rr_sel;
  logic [drvrs-1:0]  rr_oh;
  logic [IW:0]       cand;

  always_comb begin
    for (int k = 0; k < drvrs; k++) begin
      heads[k] = dato_i[k*width +: width];
    end
    head = heads[sel];
    dest = head[width-1 -: 8];
  end

  // Rotating priority search: ptr, ptr+1, ... wrapping at drvrs.
  always_comb begin
    rr_hit = 1'b0;
    rr_sel = '0;
    cand   = '0;
    for (int i = 0; i < drvrs; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(drvrs)) begin
        cand = cand - (IW+1)'(drvrs);
      end
      if (!rr_hit && pndng_i[cand[IW-1:0]]) begin
        rr_hit = 1'b1;
        rr_sel = cand[IW-1:0];
      end
    end
    rr_oh = '0;
    for (int k = 0; k < drvrs; k++) begin
      rr_oh[k] = rr_hit && (IW'(k) == rr_sel);
    end
  end

  // Destination decode of the head word; an all-zero result means drop.
  always_comb begin
    dest_push = '0;
    if (dest == bcast) begin
      for (int k = 0; k < drvrs; k++) begin
        dest_push[k] = (IW'(k) != sel);
      end
    end else if ((dest < DRVRS8) && (dest[IW-1:0] != sel)) begin
      for (int k = 0; k < drvrs; k++) begin
        dest_push[k] = (dest == 8'(k));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      sel     <= '0;
      pop_o   <= '0;
      push_o  <= '0;
      grant_o <= '0;
      dato_o  <= '0;
      busy_o  <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      sel     <= sel_nxt;
      pop_o   <= pop_nxt;
      push_o  <= push_nxt;
      grant_o <= grant_nxt;
      dato_o  <= dato_nxt;
      busy_o  <= busy_nxt;
      err_o   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    case (state)
      IDLE: begin
        if (|pndng_i) begin
          state_nxt = GRANT;
          sel_nxt   = rr_sel;
        end
      end
      GRANT: begin
        state_nxt = DELIVER;
        ptr_nxt   = (sel == IW'(drvrs-1)) ? '0 : sel + IW'(1);
      end
      DELIVER: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; they appear one cycle later.
  always_comb begin
    pop_nxt   = '0;
    push_nxt  = '0;
    grant_nxt = '0;
    dato_nxt  = '0;
    busy_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (|pndng_i) begin
          pop_nxt   = rr_oh;
          grant_nxt = rr_oh;
          busy_nxt  = 1'b1;
        end
      end
      GRANT: begin
        grant_nxt = grant_o;
        busy_nxt  = 1'b1;
        push_nxt  = dest_push;
        dato_nxt  = (|dest_push) ? head : '0;
        err_nxt   = ~(|dest_push);
      end
      default: ;
    endcase
  end

`ifdef BUS_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else begin
      if ((state == DELIVER) && (|push_o) && (pkt_cnt_o != 16'hFFFF)) begin
        pkt_cnt_o <= pkt_cnt_o + 16'd1;
      end
      if (err_o && (drop_cnt_o != 16'hFFFF)) begin
        drop_cnt_o <= drop_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (4 terminals, 16-bit packets).
// Stats checks are compiled in only when BUS_ARBITER_STATS_EN is defined.
module tb_bus_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   pndng_i;
  logic [N*W-1:0] dato_i;
  logic [N-1:0]   pop_o, push_o, grant_o;
  logic [W-1:0]   dato_o;
  logic           busy_o, err_o;
`ifdef BUS_ARBITER_STATS_EN
  logic [15:0]    pkt_cnt_o, drop_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.drvrs(N), .width(W), .bcast(8'hFF)) dut (
    .clk     (clk),
    .reset   (reset),
    .pndng_i (pndng_i),
    .dato_i  (dato_i),
    .pop_o   (pop_o),
    .push_o  (push_o),
    .dato_o  (dato_o),
    .grant_o (grant_o),
    .busy_o  (busy_o),
    .err_o   (err_o)
`ifdef BUS_ARBITER_STATS_EN
    ,
    .pkt_cnt_o  (pkt_cnt_o),
    .drop_cnt_o (drop_cnt_o)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    pndng_i = '0;
    dato_i  = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3*N+W+1:0] got;
    do_reset();
    got = {pop_o, push_o, grant_o, dato_o, busy_o, err_o};
    checks++;
    if (got !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", got);
    end
`ifdef BUS_ARBITER_STATS_EN
    checks++;
    if ({pkt_cnt_o, drop_cnt_o} !== 32'h0) begin
      errors++;
      $display("FAIL reset_stats: got %h want 0", {pkt_cnt_o, drop_cnt_o});
    end
`endif
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_pop, exp_push;
    for (int k = 0; k < N; k++) dato_i[k*W +: W] = {8'((k+1)%N), 8'(8'h40 + k)};
    pndng_i = '1;
    for (int i = 0; i < 15; i++) begin
      tick();
      exp_pop  = (i % 3 == 0) ? N'(1 << ((i/3) % N)) : '0;
      exp_push = (i % 3 == 1) ? N'(1 << (((i/3) + 1) % N)) : '0;
      checks++;
      if (pop_o !== exp_pop) begin
        errors++;
        $display("FAIL rr_pop[%0d]: got %b want %b", i, pop_o, exp_pop);
      end
      checks++;
      if (push_o !== exp_push) begin
        errors++;
        $display("FAIL rr_push[%0d]: got %b want %b", i, push_o, exp_push);
      end
    end
    pndng_i = '0;
    tick();
  endtask

  task automatic test_unicast();
    dato_i[0 +: W] = 16'h0206;
    pndng_i = 4'b0001;
    tick();
    checks++;
    if ({pop_o, grant_o, busy_o, push_o} !== {4'b0001, 4'b0001, 1'b1, 4'b0000}) begin
      errors++;
      $display("FAIL uni_grant: pop=%b grant=%b busy=%b push=%b want 0001 0001 1 0000",
               pop_o, grant_o, busy_o, push_o);
    end
    pndng_i = '0;
    tick();
    checks++;
    if (push_o !== 4'b0100) begin
      errors++;
      $display("FAIL uni_push: got %b want 0100", push_o);
    end
    checks++;
    if (dato_o !== 16'h0206) begin
      errors++;
      $display("FAIL uni_dato: got %h want 0206", dato_o);
    end
    checks++;
    if ({grant_o, pop_o, err_o, busy_o} !== {4'b0001, 4'b0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL uni_deliver_ctl: grant=%b pop=%b err=%b busy=%b want 0001 0000 0 1",
               grant_o, pop_o, err_o, busy_o);
    end
    tick();
    checks++;
    if ({grant_o, busy_o, push_o, dato_o} !== '0) begin
      errors++;
      $display("FAIL uni_idle: grant=%b busy=%b push=%b dato=%h want all 0",
               grant_o, busy_o, push_o, dato_o);
    end
  endtask

  task automatic test_broadcast();
    dato_i[1*W +: W] = 16'hFF0A;
    pndng_i = 4'b0010;
    tick();
    pndng_i = '0;
    tick();
    checks++;
    if (push_o !== 4'b1101) begin
      errors++;
      $display("FAIL bc_push: got %b want 1101", push_o);
    end
    checks++;
    if ({dato_o, err_o, grant_o} !== {16'hFF0A, 1'b0, 4'b0010}) begin
      errors++;
      $display("FAIL bc_data: dato=%h err=%b grant=%b want ff0a 0 0010", dato_o, err_o, grant_o);
    end
    tick();
  endtask

  task automatic test_drop();
    logic [W-1:0] pkts [2];
    pkts[0] = 16'h0711;
    pkts[1] = 16'h0233;
    do_reset();
    for (int p = 0; p < 2; p++) begin
      dato_i[2*W +: W] = pkts[p];
      pndng_i = 4'b0100;
      tick();
      pndng_i = '0;
      tick();
      checks++;
      if ({err_o, push_o, dato_o, grant_o} !== {1'b1, 4'b0000, 16'h0000, 4'b0100}) begin
        errors++;
        $display("FAIL drop[%0d]: err=%b push=%b dato=%h grant=%b want 1 0000 0000 0100",
                 p, err_o, push_o, dato_o, grant_o);
      end
      tick();
      checks++;
      if (err_o !== 1'b0) begin
        errors++;
        $display("FAIL drop_pulse[%0d]: err got %b want 0", p, err_o);
      end
    end
`ifdef BUS_ARBITER_STATS_EN
    checks++;
    if ({drop_cnt_o, pkt_cnt_o} !== {16'd2, 16'd0}) begin
      errors++;
      $display("FAIL drop_stats: drop=%0d pkt=%0d want 2 0", drop_cnt_o, pkt_cnt_o);
    end
`endif
  endtask

  task automatic test_reset_mid_grant();
    dato_i[3*W +: W] = 16'h0100;
    pndng_i = 4'b1000;
    tick();
    checks++;
    if ({pop_o, grant_o} !== {4'b1000, 4'b1000}) begin
      errors++;
      $display("FAIL rst_grant: pop=%b grant=%b want 1000 1000", pop_o, grant_o);
    end
    reset   = 1'b1;
    pndng_i = '0;
    tick();
    reset = 1'b0;
    checks++;
    if ({pop_o, push_o, grant_o, dato_o, busy_o, err_o} !== '0) begin
      errors++;
      $display("FAIL rst_abort: pop=%b push=%b grant=%b dato=%h busy=%b err=%b want all 0",
               pop_o, push_o, grant_o, dato_o, busy_o, err_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (push_o !== 4'b0000) begin
        errors++;
        $display("FAIL rst_nopush[%0d]: got %b want 0000", i, push_o);
      end
    end
    dato_i[1*W +: W] = 16'h0005;
    pndng_i = 4'b1010;
    tick();
    checks++;
    if (grant_o !== 4'b0010) begin
      errors++;
      $display("FAIL rst_ptr: grant got %b want 0010", grant_o);
    end
    pndng_i = '0;
    tick();
    checks++;
    if (push_o !== 4'b0001) begin
      errors++;
      $display("FAIL rst_after_push: got %b want 0001", push_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] exp_pop [6];
    logic [N-1:0] exp_push [6];
    exp_pop  = '{4'b0100, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
    exp_push = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
    dato_i[1*W +: W] = 16'h0300;
    dato_i[2*W +: W] = 16'h0000;
    pndng_i = 4'b0110;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 5) pndng_i = '0;
      checks++;
      if ({pop_o, push_o} !== {exp_pop[i], exp_push[i]}) begin
        errors++;
        $display("FAIL b2b[%0d]: pop=%b push=%b want %b %b",
                 i, pop_o, push_o, exp_pop[i], exp_push[i]);
      end
    end
    tick();
  endtask

`ifdef BUS_ARBITER_STATS_EN
  task automatic test_stats_saturation();
    force dut.pkt_cnt_o = 16'hFFFE;
    #1;
    release dut.pkt_cnt_o;
    dato_i[0 +: W] = 16'h0101;
    for (int p = 0; p < 3; p++) begin
      pndng_i = 4'b0001;
      tick();
      pndng_i = '0;
      tick();
      tick();
    end
    checks++;
    if (pkt_cnt_o !== 16'hFFFF) begin
      errors++;
      $display("FAIL stats_sat: got %h want ffff", pkt_cnt_o);
    end
  endtask
`endif

  initial begin
    reset   = 1'b1;
    pndng_i = '0;
    dato_i  = '0;
    test_reset();
    test_round_robin();
    test_unicast();
    test_broadcast();
    test_drop();
    test_reset_mid_grant();
    test_back_to_back();
`ifdef BUS_ARBITER_STATS_EN
    test_stats_saturation();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
